// File: rtl/oufbuf_rd_arbiter_if.sv
// Read-side bundle of the output-buffer arbiter: two requester ports plus the SRAM read port.
// The master side is everything around the arbiter (LCD, readback, SRAM); the slave side is the arbiter.
interface oufbuf_rd_arbiter_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 16
);
  logic              iReq0;
  logic [ADDR_W-1:0] iAddr0;
  logic              oGnt0;
  logic              oRdValid0;
  logic [DATA_W-1:0] oRdData0;

  logic              iReq1;
  logic [ADDR_W-1:0] iAddr1;
  logic              oGnt1;
  logic              oRdValid1;
  logic [DATA_W-1:0] oRdData1;

  logic              oSramRdEn;
  logic [ADDR_W-1:0] oSramRdAddr;
  logic [DATA_W-1:0] iSramRdData;

  modport master (
    output iReq0, iAddr0, iReq1, iAddr1, iSramRdData,
    input  oGnt0, oRdValid0, oRdData0, oGnt1, oRdValid1, oRdData1,
    input  oSramRdEn, oSramRdAddr
  );

  modport slave (
    input  iReq0, iAddr0, iReq1, iAddr1, iSramRdData,
    output oGnt0, oRdValid0, oRdData0, oGnt1, oRdValid1, oRdData1,
    output oSramRdEn, oSramRdAddr
  );
endinterface

// File: rtl/oufbuf_rd_arbiter.sv
// Shares the output-buffer SRAM read port between the LCD scan-out (port 0, priority)
// and the readback checker (port 1, starvation-guarded); LCD reads are black until a frame completes.
module oufbuf_rd_arbiter #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 16,
  parameter int DEPTH      = 130560,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 8
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  iFrameDone,
  oufbuf_rd_arbiter_if.slave    bus,
  output logic                  oAddrErr,
  output logic                  oFrameReady
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0]  STARVE_LIM = CNT_W'(STARVE_MAX);
  localparam logic [ADDR_W:0]   DEPTH_V    = (ADDR_W + 1)'(DEPTH);

  logic [CNT_W-1:0]  starveCnt;
  logic              frameReady;
  logic              forceGnt;
  logic              gnt0;
  logic              gnt1;
  logic              anyGnt;
  logic              inRange;
  logic              sramEn;
  logic [ADDR_W-1:0] gntAddr;

  logic [RD_LAT-1:0] pipeValid;
  logic [RD_LAT-1:0] pipePort;
  logic [RD_LAT-1:0] pipeZero;
  logic              retValid;
  logic              retPort;
  logic [DATA_W-1:0] retData;
  logic              rdValid0;
  logic              rdValid1;
  logic [DATA_W-1:0] rdHold0;
  logic [DATA_W-1:0] rdHold1;

  // Port 1 wins only when it has waited STARVE_MAX cycles or port 0 is idle; nothing is granted in reset.
  always_comb begin
    forceGnt = bus.iReq1 && (starveCnt == STARVE_LIM);
    gnt1     = !iRst && bus.iReq1 && (forceGnt || !bus.iReq0);
    gnt0     = !iRst && bus.iReq0 && !gnt1;
    anyGnt   = gnt0 || gnt1;
    gntAddr  = gnt1 ? bus.iAddr1 : bus.iAddr0;
    inRange  = {1'b0, gntAddr} < DEPTH_V;
    sramEn   = anyGnt && inRange && (gnt1 || frameReady);
  end

  assign bus.oGnt0       = gnt0;
  assign bus.oGnt1       = gnt1;
  assign bus.oSramRdEn   = sramEn;
  assign bus.oSramRdAddr = anyGnt ? gntAddr : '0;
  assign oAddrErr        = anyGnt && !inRange;
  assign oFrameReady     = frameReady;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      starveCnt <= '0;
    end else if (!bus.iReq1 || gnt1) begin
      starveCnt <= '0;
    end else if (starveCnt != STARVE_LIM) begin
      starveCnt <= starveCnt + 1'b1;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      frameReady <= 1'b0;
    end else if (iFrameDone) begin
      frameReady <= 1'b1;
    end
  end

  // Every grant enters the return pipe; zero-force marks grants that skipped the SRAM (gated or out of range).
  always_ff @(posedge iClk) begin
    if (iRst) begin
      pipeValid <= '0;
      pipePort  <= '0;
      pipeZero  <= '0;
    end else begin
      pipeValid[0] <= anyGnt;
      pipePort[0]  <= gnt1;
      pipeZero[0]  <= !sramEn;
      for (int i = 1; i < RD_LAT; i++) begin
        pipeValid[i] <= pipeValid[i-1];
        pipePort[i]  <= pipePort[i-1];
        pipeZero[i]  <= pipeZero[i-1];
      end
    end
  end

  // The last pipe stage lines up with the SRAM output register, so read data is steered straight out in that cycle.
  always_comb begin
    retValid = pipeValid[RD_LAT-1] && !iRst;
    retPort  = pipePort[RD_LAT-1];
    retData  = pipeZero[RD_LAT-1] ? '0 : bus.iSramRdData;
    rdValid0 = retValid && !retPort;
    rdValid1 = retValid && retPort;
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      rdHold0 <= '0;
      rdHold1 <= '0;
    end else begin
      if (rdValid0) begin
        rdHold0 <= retData;
      end
      if (rdValid1) begin
        rdHold1 <= retData;
      end
    end
  end

  assign bus.oRdValid0 = rdValid0;
  assign bus.oRdValid1 = rdValid1;
  assign bus.oRdData0  = iRst ? '0 : (rdValid0 ? retData : rdHold0);
  assign bus.oRdData1  = iRst ? '0 : (rdValid1 ? retData : rdHold1);

endmodule

// File: tb/tb_oufbuf_rd_arbiter.sv
// Randomised bench for oufbuf_rd_arbiter: a queue-based model of grants, starvation and
// in-order returns predicts every output each cycle, alongside directed scenario checks.
module tb_oufbuf_rd_arbiter;

  localparam int ADDR_W     = 17;
  localparam int DATA_W     = 16;
  localparam int DEPTH      = 130560;
  localparam int RD_LAT     = 2;
  localparam int STARVE_MAX = 8;

  logic iClk = 1'b0;
  logic iRst;
  logic iFrameDone;
  logic oAddrErr;
  logic oFrameReady;

  int nChecks = 0;
  int nFails  = 0;

  always #5 iClk = ~iClk;

  oufbuf_rd_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  oufbuf_rd_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
    .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .iClk(iClk),
    .iRst(iRst),
    .iFrameDone(iFrameDone),
    .bus(bus),
    .oAddrErr(oAddrErr),
    .oFrameReady(oFrameReady)
  );

  function automatic logic [15:0] memWord(input logic [16:0] a);
    return a[15:0];
  endfunction

  // SRAM with RD_LAT-cycle registered read; junk appears whenever no read was issued.
  logic [DATA_W-1:0] sramPipe [RD_LAT];
  always @(posedge iClk) begin
    sramPipe[0] <= bus.oSramRdEn ? memWord(bus.oSramRdAddr) : DATA_W'($urandom);
    for (int i = 1; i < RD_LAT; i++) sramPipe[i] <= sramPipe[i-1];
  end
  assign bus.iSramRdData = sramPipe[RD_LAT-1];

  typedef struct {
    int          due;
    bit          port;
    logic [15:0] data;
  } ret_t;

  ret_t        retQ[$];
  int          cyc      = 0;
  int          starve   = 0;
  bit          frameRdy = 1'b0;
  logic [15:0] last0    = 16'h0;
  logic [15:0] last1    = 16'h0;
  logic [55:0] expVec;
  logic [55:0] obsVec;

  assign obsVec = {bus.oGnt0, bus.oGnt1, bus.oSramRdEn, oAddrErr, bus.oRdValid0, bus.oRdValid1,
                   oFrameReady, bus.oSramRdAddr, bus.oRdData0, bus.oRdData1};

  // Drives one cycle of inputs, predicts this cycle's outputs into expVec, then advances the model past the edge.
  task automatic drive(input bit rst, input bit fd, input bit q0, input logic [16:0] a0,
                       input bit q1, input logic [16:0] a1);
    bit          g0, g1, forced, inR, en, v0, v1;
    logic [16:0] ga;
    @(negedge iClk);
    iRst = rst; iFrameDone = fd;
    bus.iReq0 = q0; bus.iAddr0 = a0; bus.iReq1 = q1; bus.iAddr1 = a1;
    #1;
    cyc++;
    g0 = 1'b0; g1 = 1'b0; v0 = 1'b0; v1 = 1'b0;
    if (!rst) begin
      forced = q1 && (starve == STARVE_MAX);
      g1 = q1 && (forced || !q0);
      g0 = q0 && !g1;
    end
    ga  = g1 ? a1 : a0;
    inR = (ga < DEPTH);
    en  = (g0 || g1) && inR && (g1 || frameRdy);
    if (!rst && retQ.size() > 0 && retQ[0].due == cyc) begin
      if (retQ[0].port) begin v1 = 1'b1; last1 = retQ[0].data; end
      else              begin v0 = 1'b1; last0 = retQ[0].data; end
      void'(retQ.pop_front());
    end
    expVec = {g0, g1, en, (g0 || g1) && !inR, v0, v1, frameRdy,
              (g0 || g1) ? ga : 17'd0, rst ? 16'h0 : last0, rst ? 16'h0 : last1};
    if (rst) begin
      starve = 0; frameRdy = 1'b0; retQ.delete(); last0 = 16'h0; last1 = 16'h0;
    end else begin
      if (!q1 || g1)              starve = 0;
      else if (starve < STARVE_MAX) starve++;
      if (fd) frameRdy = 1'b1;
      if (g0 || g1) retQ.push_back('{cyc + RD_LAT, g1, en ? memWord(ga) : 16'h0});
    end
  endtask

  function automatic logic [16:0] randAddr();
    if ($urandom_range(0, 15) == 0) return 17'(DEPTH + $urandom_range(0, 3));
    return 17'($urandom_range(0, DEPTH - 1));
  endfunction

  task automatic test_reset();
    drive(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 22; k++) begin
      drive(k < 2, 0, 0, 0, 0, 0);
      nChecks++;
      if (obsVec !== expVec) begin
        nFails++;
        $display("[TB] FAIL reset_idle cycle %0d: got %h expected %h", cyc, obsVec, expVec);
      end
    end
  endtask

  task automatic test_lcd_gating();
    for (int k = 0; k < RD_LAT + 2; k++) begin
      drive(0, 0, k == 0, 17'd5, 0, 0);
      nChecks++;
      if (obsVec !== expVec) begin
        nFails++;
        $display("[TB] FAIL lcd_before_frame cycle %0d: got %h expected %h", cyc, obsVec, expVec);
      end
    end
  endtask

  task automatic test_burst();
    int a = 0;
    int budget = 0;
    drive(0, 1, 0, 0, 0, 0);
    nChecks++;
    if (obsVec !== expVec) begin
      nFails++;
      $display("[TB] FAIL frame_done cycle %0d: got %h expected %h", cyc, obsVec, expVec);
    end
    while (a < 480 && budget < 1000) begin
      drive(0, 0, 1, 17'(a), 0, 0);
      nChecks++;
      if (obsVec !== expVec) begin
        nFails++;
        $display("[TB] FAIL lcd_burst cycle %0d: got %h expected %h", cyc, obsVec, expVec);
      end
      if (bus.oGnt0 === 1'b1) a++;
      budget++;
    end
    nChecks++;
    if (budget !== 480) begin
      nFails++;
      $display("[TB] FAIL burst_cycles: took %0d cycles, required 480", budget);
    end
    for (int k = 0; k < RD_LAT + 2; k++) begin
      drive(0, 0, 0, 0, 0, 0);
      nChecks++;
      if (obsVec !== expVec) begin
        nFails++;
        $display("[TB] FAIL burst_drain cycle %0d: got %h expected %h", cyc, obsVec, expVec);
      end
    end
  endtask

  task automatic test_starvation();
    bit want1;
    for (int k = 0; k < 4 * (STARVE_MAX + 1); k++) begin
      drive(0, 0, 1, 17'd100, 1, 17'd200);
      want1 = ((k % (STARVE_MAX + 1)) == STARVE_MAX);
      nChecks++;
      if (obsVec !== expVec) begin
        nFails++;
        $display("[TB] FAIL starvation cycle %0d: got %h expected %h", cyc, obsVec, expVec);
      end
      nChecks++;
      if (bus.oGnt1 !== want1 || bus.oGnt0 !== !want1) begin
        nFails++;
        $display("[TB] FAIL starve_pattern k=%0d: gnt0/gnt1 %b%b required %b%b",
                 k, bus.oGnt0, bus.oGnt1, !want1, want1);
      end
    end
    for (int k = 0; k < RD_LAT + 2; k++) begin
      drive(0, 0, 0, 0, 0, 0);
      nChecks++;
      if (obsVec !== expVec) begin
        nFails++;
        $display("[TB] FAIL starve_drain cycle %0d: got %h expected %h", cyc, obsVec, expVec);
      end
    end
  endtask

  task automatic test_out_of_range();
    for (int k = 0; k < RD_LAT + 3; k++) begin
      drive(0, 0, 0, 0, k < 2, (k == 0) ? 17'(DEPTH) : 17'(DEPTH - 1));
      nChecks++;
      if (obsVec !== expVec) begin
        nFails++;
        $display("[TB] FAIL out_of_range cycle %0d: got %h expected %h", cyc, obsVec, expVec);
      end
      if (k < 2) begin
        nChecks++;
        if (oAddrErr !== (k == 0) || bus.oSramRdEn !== (k == 1)) begin
          nFails++;
          $display("[TB] FAIL addr_err_edge k=%0d: err/en %b%b required %b%b",
                   k, oAddrErr, bus.oSramRdEn, k == 0, k == 1);
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    bit seen1 = 1'b0;
    for (int k = 0; k < RD_LAT + 5; k++) begin
      drive(k == 1, 0, 0, 0, k == 0, 17'd77);
      nChecks++;
      if (obsVec !== expVec) begin
        nFails++;
        $display("[TB] FAIL reset_midflight cycle %0d: got %h expected %h", cyc, obsVec, expVec);
      end
      if (k > 0 && bus.oRdValid1 === 1'b1) seen1 = 1'b1;
    end
    nChecks++;
    if (seen1 !== 1'b0 || oFrameReady !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL flushed_return: valid1 seen %b frameReady %b, required 0 0", seen1, oFrameReady);
    end
  endtask

  task automatic test_random();
    bit          pend0 = 1'b0, pend1 = 1'b0;
    logic [16:0] pa0 = '0, pa1 = '0;
    for (int k = 0; k < 600; k++) begin
      if (!pend0 && $urandom_range(0, 2) == 0) begin pend0 = 1'b1; pa0 = randAddr(); end
      if (!pend1 && $urandom_range(0, 3) == 0) begin pend1 = 1'b1; pa1 = randAddr(); end
      drive($urandom_range(0, 79) == 0, $urandom_range(0, 49) == 0, pend0, pa0, pend1, pa1);
      nChecks++;
      if (obsVec !== expVec) begin
        nFails++;
        $display("[TB] FAIL random cycle %0d: got %h expected %h", cyc, obsVec, expVec);
      end
      if (bus.oGnt0 === 1'b1) pend0 = 1'b0;
      if (bus.oGnt1 === 1'b1) pend1 = 1'b0;
    end
    for (int k = 0; k < RD_LAT + 2; k++) begin
      drive(0, 0, 0, 0, 0, 0);
      nChecks++;
      if (obsVec !== expVec) begin
        nFails++;
        $display("[TB] FAIL random_drain cycle %0d: got %h expected %h", cyc, obsVec, expVec);
      end
    end
  endtask

  initial begin
    iRst = 1'b1; iFrameDone = 1'b0;
    bus.iReq0 = 1'b0; bus.iAddr0 = '0; bus.iReq1 = 1'b0; bus.iAddr1 = '0;
    test_reset();
    test_lcd_gating();
    test_burst();
    test_starvation();
    test_out_of_range();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/oufbuf_rd_arbiter.md
Name: oufbuf_rd_arbiter

Overview:
- Shares the single read port of the RGB565 output-buffer dual-port SRAM (480x272 = 130560 words, 16-bit) between two requesters.
- Port 0 is the LCD scan-out reader (high priority, hard real-time). Port 1 is a readback/checker reader (low priority, starvation-guarded).
- Sits between the output buffer's read port and the LCD controller / readback logic inside cnn_top.
- Gates LCD reads to black until the first complete frame is flagged done.

Parameters:
- ADDR_W, 17, SRAM read-address width.
- DATA_W, 16, RGB565 word width.
- DEPTH, 130560, valid address range 0..DEPTH-1.
- RD_LAT, 1, SRAM read latency in cycles (1..4).
- STARVE_MAX, 8, consecutive denied port-1 cycles before port 1 is force-granted once.

Ports:
- iClk  in  1  system clock
- iRst  in  1  synchronous, active-high reset
- iFrameDone  in  1  one-cycle pulse: output buffer holds a complete frame
- iReq0  in  1  LCD read request
- iAddr0  in  ADDR_W  LCD read address
- oGnt0  out  1  port 0 request accepted this cycle
- oRdValid0  out  1  port 0 read data valid
- oRdData0  out  DATA_W  port 0 read data
- iReq1  in  1  readback read request
- iAddr1  in  ADDR_W  readback read address
- oGnt1  out  1  port 1 request accepted this cycle
- oRdValid1  out  1  port 1 read data valid
- oRdData1  out  DATA_W  port 1 read data
- oSramRdEn  out  1  SRAM read enable
- oSramRdAddr  out  ADDR_W  SRAM read address
- iSramRdData  in  DATA_W  SRAM read data, RD_LAT cycles after oSramRdEn
- oAddrErr  out  1  one-cycle pulse: an out-of-range address was granted
- oFrameReady  out  1  sticky flag: a frame has completed

Behaviour:
- Reset (iRst high at a posedge): all outputs 0; starvation counter 0; frame-ready flag 0; return pipeline flushed. Any in-flight returns are discarded and never produce a valid.
- Handshake: a requester holds iReqN/iAddrN stable until it sees oGntN=1. The grant is combinational in the same cycle, and the request is consumed at that posedge. At most one grant per cycle.
- Arbitration, evaluated each cycle:
  - Forced grant: if iReq1=1 and starve counter == STARVE_MAX, grant port 1, even if iReq0=1.
  - Otherwise, if iReq0=1, grant port 0.
  - Otherwise, if iReq1=1, grant port 1.
  - Otherwise, no grant.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) each cycle iReq1=1 and oGnt1=0.
  - Clears on oGnt1=1 or when iReq1=0.
- SRAM drive: oSramRdEn = a grant to an in-range address (addr < DEPTH), and, for port 0 only, oFrameReady=1. oSramRdAddr = the granted address, else 0.
- Out-of-range grant (addr >= DEPTH): no SRAM access; oAddrErr pulses in the grant cycle; the return data is 0x0000.
- LCD gating: a port-0 grant while oFrameReady=0 performs no SRAM read and returns 0x0000 (black). This is not an error.
- oFrameReady:
  - Set on the cycle after iFrameDone=1.
  - Stays set until reset.
  - iFrameDone is ignored while iRst=1.
- Return path: RD_LAT-deep shift register of {valid, port, zero-force}.
  - oRdValidN and oRdDataN are registered and appear exactly RD_LAT cycles after the grant cycle.
  - Data is iSramRdData, or 0x0000 when zero-force is set.
  - Returns are in grant order, one per cycle max, fully pipelined (back-to-back grants give back-to-back valids).
  - oRdDataN holds its last value when oRdValidN=0.
- Simultaneous iReq0 and iReq1 with counter < STARVE_MAX: port 0 wins and the counter increments.
- Reset mid-operation: a grant in the reset cycle is suppressed (oGnt0 = oGnt1 = 0 while iRst=1).

Test Plan:
- Reset then idle: iRst=1 for 3 cycles, no requests -> all outputs 0, oFrameReady=0, no oRdValid for 20 cycles.
- LCD before frame: iReq0=1, iAddr0=5, oFrameReady=0 -> oGnt0=1 same cycle, oSramRdEn=0, oRdValid0=1 RD_LAT cycles later with oRdData0=0x0000.
- Frame then LCD burst: preload SRAM model word[k]=k[15:0]; pulse iFrameDone; stream iAddr0=0..479 with iReq0 held high -> 480 consecutive grants; oRdData0 = 0..479 in order, each exactly RD_LAT cycles after its grant.
- Starvation: iReq0 and iReq1 held high continuously -> port 1 granted once every STARVE_MAX+1 cycles (cycles 9, 18, ... for default 8); port 0 takes all other cycles.
- Out of range: port-1 grant with iAddr1=130560 -> oAddrErr pulses, oSramRdEn=0, oRdData1=0x0000 with oRdValid1=1; iAddr1=130559 -> normal read, no error.
- Reset mid-flight: with RD_LAT=2, assert iRst the cycle after a port-1 grant -> no oRdValid1 ever appears for that grant; oFrameReady clears to 0.
